// File: rtl/qspi_host_ctrl_if.sv
// Request and data streaming port of the QSPI host controller.
// Signal names are seen from the controller side.
interface qspi_host_ctrl_if #(
    parameter int LEN_W = 8
);
    logic             req_valid_i;
    logic             req_ready_o;
    logic [7:0]       req_cmd_i;
    logic [31:0]      req_addr_i;
    logic [4:0]       req_dummy_i;
    logic             req_write_i;
    logic [LEN_W-1:0] req_len_i;
    logic [31:0]      wdata_i;
    logic             wdata_valid_i;
    logic             wdata_ready_o;
    logic [31:0]      rdata_o;
    logic             rdata_valid_o;
    logic             busy_o;

    modport slave (
        input  req_valid_i, req_cmd_i, req_addr_i,
        input  req_dummy_i, req_write_i, req_len_i,
        input  wdata_i, wdata_valid_i,
        output req_ready_o, wdata_ready_o,
        output rdata_o, rdata_valid_o, busy_o
    );

    modport master (
        output req_valid_i, req_cmd_i, req_addr_i,
        output req_dummy_i, req_write_i, req_len_i,
        output wdata_i, wdata_valid_i,
        input  req_ready_o, wdata_ready_o,
        input  rdata_o, rdata_valid_o, busy_o
    );
endinterface

// File: rtl/qspi_host_ctrl.sv
// QSPI mode-0 initiator: cmd, addr, dummy and data phases.
// Define QSPI_HOST_QUAD_CMD_EN for a 2-SCK quad command phase.
module qspi_host_ctrl #(
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = 8,
    parameter int CS_IDLE = 4
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    qspi_host_ctrl_if.slave  bus,
    output logic             spi_sce_o,
    output logic             spi_sck_o,
    output logic [3:0]       spi_io_o,
    input  logic [3:0]       spi_io_i,
    output logic             spi_io_oe_o
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (CS_IDLE > 0) ? $clog2(CS_IDLE + 1) : 1;
    localparam logic [DW-1:0] DIV_LD = DW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDLE_LD = IW'(CS_IDLE);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_CMD, S_ADDR,
        S_DUMMY, S_DATA, S_WAIT, S_HOLD
    } state_t;

    state_t           state_q, nxt;
    logic [DW-1:0]    div_q;
    logic [IW-1:0]    idle_q;
    logic             sce_q, sck_q, oe_q;
    logic [3:0]       io_q;
    logic [31:0]      sh_q;
    logic [31:0]      addr_q;
    logic [27:0]      rd_q;
    logic [4:0]       cnt_q;
    logic [4:0]       dummy_q;
    logic             wr_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] words_q;
    logic [31:0]      rdata_q;
    logic             rvalid_q, wready_q;
    logic             tick, ready, accept;

    assign tick   = (div_q == '0);
    assign ready  = (state_q == S_IDLE) && (idle_q == '0);
    assign accept = ready && bus.req_valid_i;

    assign bus.req_ready_o   = ready;
    assign bus.busy_o        = (state_q != S_IDLE);
    assign bus.rdata_o       = rdata_q;
    assign bus.rdata_valid_o = rvalid_q;
    assign bus.wdata_ready_o = wready_q;
    assign spi_sce_o   = sce_q;
    assign spi_sck_o   = sck_q;
    assign spi_io_o    = io_q;
    assign spi_io_oe_o = oe_q;

    // Phase that follows the current one once its last SCK falls.
    always_comb begin
        nxt = S_HOLD;
        unique case (1'b1)
            state_q == S_CMD:
                nxt = S_ADDR;
            state_q == S_ADDR:
                nxt = (dummy_q != '0) ? S_DUMMY :
                      (len_q != '0) ? S_DATA : S_HOLD;
            state_q == S_DUMMY:
                nxt = (len_q != '0) ? S_DATA : S_HOLD;
            state_q == S_DATA:
                nxt = (words_q != 1) ? S_DATA : S_HOLD;
            default:
                nxt = S_HOLD;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q  <= S_IDLE;
            div_q    <= '0;
            idle_q   <= IDLE_LD;
            sce_q    <= 1'b1;
            sck_q    <= 1'b0;
            oe_q     <= 1'b0;
            io_q     <= '0;
            sh_q     <= '0;
            addr_q   <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            dummy_q  <= '0;
            wr_q     <= 1'b0;
            len_q    <= '0;
            words_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            wready_q <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            wready_q <= 1'b0;
            if (state_q != S_IDLE && state_q != S_WAIT)
                div_q <= tick ? DIV_LD : div_q - 1'b1;
            unique case (state_q)
                S_IDLE: begin
                    if (idle_q != '0)
                        idle_q <= idle_q - 1'b1;
                    if (accept) begin
                        addr_q  <= bus.req_addr_i;
                        dummy_q <= bus.req_dummy_i;
                        wr_q    <= bus.req_write_i;
                        len_q   <= bus.req_len_i;
                        words_q <= bus.req_len_i;
                        sce_q   <= 1'b0;
                        oe_q    <= 1'b1;
                        div_q   <= DIV_LD;
                        state_q <= S_SETUP;
`ifdef QSPI_HOST_QUAD_CMD_EN
                        io_q  <= bus.req_cmd_i[7:4];
                        sh_q  <= {bus.req_cmd_i[3:0], 28'h0};
                        cnt_q <= 5'd1;
`else
                        io_q  <= {3'b000, bus.req_cmd_i[7]};
                        sh_q  <= {bus.req_cmd_i[6:0], 25'h0};
                        cnt_q <= 5'd7;
`endif
                    end
                end
                S_SETUP: begin
                    if (tick) begin
                        sck_q   <= 1'b1;
                        state_q <= S_CMD;
                    end
                end
                S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
                    if (tick && !sck_q) begin
                        sck_q <= 1'b1;
                        if (state_q == S_DATA && !wr_q) begin
                            rd_q <= {rd_q[23:0], spi_io_i};
                            if (cnt_q == '0) begin
                                rdata_q  <= {rd_q, spi_io_i};
                                rvalid_q <= 1'b1;
                            end
                        end
                    end else if (tick) begin
                        sck_q <= 1'b0;
                        if (cnt_q != '0) begin
                            cnt_q <= cnt_q - 1'b1;
                            if (state_q == S_CMD) begin
`ifdef QSPI_HOST_QUAD_CMD_EN
                                io_q <= sh_q[31:28];
                                sh_q <= {sh_q[27:0], 4'h0};
`else
                                io_q <= {3'b000, sh_q[31]};
                                sh_q <= {sh_q[30:0], 1'b0};
`endif
                            end else if (state_q == S_ADDR ||
                                         (state_q == S_DATA && wr_q)) begin
                                io_q <= sh_q[31:28];
                                sh_q <= {sh_q[27:0], 4'h0};
                            end
                        end else begin
                            if (state_q == S_DATA)
                                words_q <= words_q - 1'b1;
                            unique case (nxt)
                                S_ADDR: begin
                                    io_q    <= addr_q[31:28];
                                    sh_q    <= {addr_q[27:0], 4'h0};
                                    cnt_q   <= 5'd7;
                                    state_q <= S_ADDR;
                                end
                                S_DUMMY: begin
                                    oe_q    <= 1'b0;
                                    io_q    <= '0;
                                    cnt_q   <= dummy_q - 1'b1;
                                    state_q <= S_DUMMY;
                                end
                                S_DATA: begin
                                    cnt_q <= 5'd7;
                                    if (!wr_q) begin
                                        oe_q    <= 1'b0;
                                        io_q    <= '0;
                                        state_q <= S_DATA;
                                    end else if (bus.wdata_valid_i) begin
                                        oe_q     <= 1'b1;
                                        io_q     <= bus.wdata_i[31:28];
                                        sh_q     <= {bus.wdata_i[27:0], 4'h0};
                                        wready_q <= 1'b1;
                                        state_q  <= S_DATA;
                                    end else begin
                                        state_q <= S_WAIT;
                                    end
                                end
                                default: state_q <= S_HOLD;
                            endcase
                        end
                    end
                end
                // SCK parked low until the next write word shows up.
                S_WAIT: begin
                    if (bus.wdata_valid_i) begin
                        oe_q     <= 1'b1;
                        io_q     <= bus.wdata_i[31:28];
                        sh_q     <= {bus.wdata_i[27:0], 4'h0};
                        wready_q <= 1'b1;
                        cnt_q    <= 5'd7;
                        div_q    <= DIV_LD;
                        state_q  <= S_DATA;
                    end
                end
                S_HOLD: begin
                    if (tick) begin
                        sce_q   <= 1'b1;
                        oe_q    <= 1'b0;
                        io_q    <= '0;
                        idle_q  <= IDLE_LD;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qspi_host_ctrl.sv
// Directed bench for qspi_host_ctrl with a simple quad responder.
// Build with QSPI_HOST_QUAD_CMD_EN to exercise the quad command phase.
module tb_qspi_host_ctrl;
    localparam int CS_IDLE = 4;
`ifdef QSPI_HOST_QUAD_CMD_EN
    localparam int CN = 2;
`else
    localparam int CN = 8;
`endif

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] addr;
        int          dummy;
        bit          wr;
        int          len;
        logic [31:0] w0;
        logic [31:0] w1;
        int          exp_sck;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic spi_sce, spi_sck, spi_oe;
    logic [3:0] spi_io_o;
    logic [3:0] spi_io_i = 4'h0;

    always #5 clk = ~clk;

    qspi_host_ctrl_if #(.LEN_W(8)) bus ();

    qspi_host_ctrl #(.CLK_DIV(2), .LEN_W(8), .CS_IDLE(CS_IDLE)) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .bus        (bus),
        .spi_sce_o  (spi_sce),
        .spi_sck_o  (spi_sck),
        .spi_io_o   (spi_io_o),
        .spi_io_i   (spi_io_i),
        .spi_io_oe_o(spi_oe)
    );

    int tests = 0;
    int fails = 0;

    vec_t cur;
    vec_t vt[5];
    int rise;
    int base;
    int wcnt, rcnt, widx;
    int stall_cnt;
    int snap;
    bit stall_en;
    logic [3:0] nlog[0:127];
    logic       oelog[0:127];
    logic [31:0] rlog[0:7];

    task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] wsel(int k);
        return (k == 0) ? cur.w0 : cur.w1;
    endfunction

    function automatic logic [3:0] nib(logic [31:0] w, int k);
        logic [31:0] t;
        t = w >> (28 - 4 * k);
        return t[3:0];
    endfunction

    // Capture driven nibbles and answer reads one SCK ahead.
    always @(posedge spi_sck) begin
        int j;
        if (!spi_sce) begin
            if (rise < 128) begin
                nlog[rise] = spi_io_o;
                oelog[rise] = spi_oe;
            end
            rise++;
            j = rise - base;
            if (!cur.wr && j >= 0 && j < cur.len * 8)
                spi_io_i = nib(wsel(j / 8), j % 8);
        end
    end

    always @(posedge spi_sce) spi_io_i = 4'h0;

    always @(negedge clk) begin
        if (bus.rdata_valid_o) begin
            if (rcnt < 8) rlog[rcnt] = bus.rdata_o;
            rcnt++;
        end
        if (bus.wdata_ready_o) begin
            wcnt++;
            widx++;
            bus.wdata_i = wsel(widx);
            if (stall_en && widx == 1) begin
                bus.wdata_valid_i = 1'b0;
                stall_cnt = 56;
            end
        end else if (stall_cnt > 0) begin
            stall_cnt--;
            if (stall_cnt == 20) snap = rise;
            if (stall_cnt == 1) begin
                check("stall_sck_frozen", rise, snap);
                check("stall_cs_low", {31'b0, spi_sce}, 0);
                check("stall_sck_low", {31'b0, spi_sck}, 0);
            end
            if (stall_cnt == 0) bus.wdata_valid_i = 1'b1;
        end
    end

    task automatic start(vec_t v);
        int n;
        cur = v;
        rise = 0;
        wcnt = 0;
        rcnt = 0;
        widx = 0;
        base = CN + 8 + v.dummy;
        bus.wdata_i = v.w0;
        bus.wdata_valid_i = v.wr;
        n = 0;
        while (!bus.req_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("req_ready", {31'b0, bus.req_ready_o}, 1);
        bus.req_cmd_i = v.cmd;
        bus.req_addr_i = v.addr;
        bus.req_dummy_i = 5'(v.dummy);
        bus.req_write_i = v.wr;
        bus.req_len_i = 8'(v.len);
        bus.req_valid_i = 1'b1;
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
        @(negedge clk);
        check("busy_set", {31'b0, bus.busy_o}, 1);
    endtask

    task automatic run(vec_t v, string nm);
        int n, serr, oerr;
        logic [3:0] e;
        start(v);
        n = 0;
        while (bus.busy_o && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_done"}, {31'b0, bus.busy_o}, 0);
        check({nm, "_sck"}, rise, v.exp_sck);
        serr = 0;
        oerr = 0;
        for (int i = 0; i < rise && i < 128; i++) begin
            e = 4'h0;
            if (i < CN) begin
`ifdef QSPI_HOST_QUAD_CMD_EN
                e = (i == 0) ? v.cmd[7:4] : v.cmd[3:0];
`else
                e = {3'b000, v.cmd[7 - i]};
`endif
                if (nlog[i] !== e) serr++;
                if (oelog[i] !== 1'b1) oerr++;
            end else if (i < CN + 8) begin
                e = nib(v.addr, i - CN);
                if (nlog[i] !== e) serr++;
                if (oelog[i] !== 1'b1) oerr++;
            end else if (i < base) begin
                if (oelog[i] !== 1'b0) oerr++;
            end else begin
                if (v.wr) begin
                    e = nib(wsel((i - base) / 8), (i - base) % 8);
                    if (nlog[i] !== e) serr++;
                end
                if (oelog[i] !== v.wr) oerr++;
            end
        end
        check({nm, "_nibbles"}, serr, 0);
        check({nm, "_oe"}, oerr, 0);
        check({nm, "_wready"}, wcnt, v.wr ? v.len : 0);
        check({nm, "_rvalid"}, rcnt, v.wr ? 0 : v.len);
        for (int k = 0; k < v.len && !v.wr; k++)
            check({nm, "_rdata"}, rlog[k], wsel(k));
    endtask

    initial begin
        int n, gap;
        bus.req_valid_i = 1'b0;
        bus.req_cmd_i = '0;
        bus.req_addr_i = '0;
        bus.req_dummy_i = '0;
        bus.req_write_i = 1'b0;
        bus.req_len_i = '0;
        bus.wdata_i = '0;
        bus.wdata_valid_i = 1'b0;
        stall_en = 0;
        stall_cnt = 0;
        rise = 0;
        base = 100;
        cur = '{8'h0, 32'h0, 0, 1'b1, 0, 32'h0, 32'h0, 0};

        vt[0] = '{8'h32, 32'h0000_1234, 0, 1'b1, 2,
                  32'hDEAD_BEEF, 32'h0123_4567, CN + 8 + 16};
        vt[1] = '{8'hEB, 32'h0000_0010, 6, 1'b0, 1,
                  32'hA5A5_5A5A, 32'h0, CN + 8 + 6 + 8};
        vt[2] = '{8'h06, 32'h0000_0000, 0, 1'b0, 0,
                  32'h0, 32'h0, CN + 8};
        vt[3] = '{8'h6B, 32'hFFFF_FFFF, 31, 1'b0, 2,
                  32'h1357_9BDF, 32'h2468_ACE0, CN + 8 + 31 + 16};
        vt[4] = '{8'h38, 32'h89AB_CDEF, 3, 1'b1, 1,
                  32'h0F0F_0F0F, 32'h0, CN + 8 + 3 + 8};

        repeat (3) @(negedge clk);
        check("rst_sce", {31'b0, spi_sce}, 1);
        check("rst_sck", {31'b0, spi_sck}, 0);
        check("rst_oe", {31'b0, spi_oe}, 0);
        check("rst_io", {28'b0, spi_io_o}, 0);
        check("rst_ready", {31'b0, bus.req_ready_o}, 0);
        check("rst_busy", {31'b0, bus.busy_o}, 0);
        check("rst_rdata", bus.rdata_o, 0);
        check("rst_pulses",
              {30'b0, bus.rdata_valid_o, bus.wdata_ready_o}, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++)
            run(vt[i], $sformatf("vec%0d", i));

        stall_en = 1;
        run(vt[0], "stall");
        stall_en = 0;

        // Back-to-back requests with valid held high.
        cur = vt[2];
        bus.req_cmd_i = 8'h06;
        bus.req_len_i = '0;
        bus.req_dummy_i = '0;
        bus.req_write_i = 1'b0;
        bus.req_valid_i = 1'b1;
        n = 0;
        while (spi_sce && n < 100) begin @(negedge clk); n++; end
        n = 0;
        while (!spi_sce && n < 500) begin @(negedge clk); n++; end
        gap = 0;
        while (spi_sce && gap < 100) begin @(negedge clk); gap++; end
        bus.req_valid_i = 1'b0;
        check("b2b_gap_ge", {31'b0, gap >= CS_IDLE}, 1);
        check("b2b_second_cs", {31'b0, spi_sce}, 0);
        n = 0;
        while (bus.busy_o && n < 500) begin @(negedge clk); n++; end
        check("b2b_done", {31'b0, bus.busy_o}, 0);

        // Reset in the middle of the address phase.
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        start(vt[1]);
        n = 0;
        while (rise < CN + 3 && n < 500) begin @(negedge clk); n++; end
        check("abort_in_addr", {31'b0, rise >= CN + 3 && rise < CN + 8}, 1);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_sce", {31'b0, spi_sce}, 1);
        check("abort_sck", {31'b0, spi_sck}, 0);
        check("abort_oe", {31'b0, spi_oe}, 0);
        check("abort_busy", {31'b0, bus.busy_o}, 0);
        check("abort_ready", {31'b0, bus.req_ready_o}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        while (!bus.req_ready_o && n < 50) begin @(negedge clk); n++; end
        check("abort_ready_delay", n, CS_IDLE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
